vga_pattern_renderer: RTL and testbench
=======================================

# vga_pattern_renderer

Parametrised test-pattern renderer between the VGA timing generator and the colour DAC pins. It takes the pixel coordinates and active-video flag from the timing generator and drives multi-bit RGB through a 2-stage pipeline. Four runtime-selectable patterns are supported: solid white, eight colour bars, checkerboard, and an animated bouncing box. Mode changes take effect only at frame boundaries, so no frame is ever torn.

## Interface
- `COLOR_W`, 4: bits per colour channel; full scale is all ones.
- `H_VIDEO`, 640: active pixels per line.
- `V_VIDEO`, 480: active lines per frame.
- `BOX_SIZE`, 32: side of the bouncing box, in pixels.
- `CHECKER_LOG2`, 5: checker square side is 2^CHECKER_LOG2 pixels.

Ports:
- `clk_0`  in  1  25 MHz pixel clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `pixel_x`  in  10  horizontal pixel position.
- `pixel_y`  in  10  vertical line position.
- `video_on`  in  1  active-video flag.
- `mode`  in  2  requested pattern; sampled at the frame boundary.
- `red`, `green`, `blue`  out  COLOR_W each  registered colour outputs.
- `frame_tick`  out  1  one-cycle pulse marking end of the active frame.

## Operation
- **Last active pixel (LAP):** a cycle in which `video_on`=1, `pixel_x`=H_VIDEO-1 and `pixel_y`=V_VIDEO-1.
- **Frame update on LAP:**
  - `active_mode` ← `mode`.
  - Box position steps once (bouncing box only).
  - `frame_tick` pulses.
- **Mode 0, solid:** every active pixel is full-scale white.
- **Mode 1, colour bars:**
  - Bar width W = H_VIDEO/8 (integer division).
  - Bar index = number of boundaries k·W (k = 1..7) that are ≤ `pixel_x`; any remainder pixels fall into bar 7.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Each channel is either 0 or all ones.
- **Mode 2, checkerboard:** white when `pixel_x[CHECKER_LOG2] ^ pixel_y[CHECKER_LOG2]` = 1, black otherwise.
- **Mode 3, bouncing box:**
  - Pixels inside the box are white: box_x ≤ `pixel_x` < box_x+BOX_SIZE, and likewise in y.
  - All other active pixels are blue.
- **Box motion:**
  - box_x/box_y are 10-bit registers; dir_x/dir_y are 1 bit each (1 = increasing).
  - Range is x ∈ [0, H_VIDEO-BOX_SIZE], y ∈ [0, V_VIDEO-BOX_SIZE].
  - Per LAP, each axis independently:
    - Moving + at the maximum: direction flips and the position decrements by 1.
    - Moving − at 0: direction flips and the position increments by 1.
    - Otherwise the position moves by ±1.
  - The position never leaves its range.
- **Blanking:** `video_on`=0 forces RGB = 0 in every mode.

## Timing
- **Latency:** 2 cycles from `pixel_x`/`pixel_y`/`video_on` to RGB.
  - Stage 1 registers the pattern decision and the delayed `video_on`.
  - Stage 2 registers the channel values.
  - The timing generator must delay hsync/vsync by 2 cycles to match.
- **Mode timing:** `active_mode` and box position update on the clock edge that samples LAP. Pixels sampled from the next cycle onward use the new values.
- **`frame_tick`:** high exactly 1 cycle, in the cycle after the LAP edge.
- **Reset** (asynchronous assert, synchronous use after deassert):
  - RGB = 0, `frame_tick` = 0, pipeline `video_on` stages = 0.
  - `active_mode` = 0.
  - box_x = box_y = 0, dir_x = dir_y = 1.
- **Reset mid-frame:** output is black until the next LAP, except mode 0, which resumes immediately after deassertion. No partial box step occurs.
- **`mode` changes away from LAP:** ignored until the next LAP.

## Configuration
- **`VGA_RENDERER_BOUNCE_EN` defined:** mode 3 and the box registers are present.
- **Not defined:**
  - The box logic is removed.
  - Mode 3 renders solid black in active video.
  - `frame_tick` and the mode latching are unchanged.

## Structure
- Shared package `vga_pkg` holds:
  - Mode constants `MODE_SOLID`/`MODE_BARS`/`MODE_CHECKER`/`MODE_BOX` (values 0–3).
  - The 3-bit RGB bar colour constants.
  - Default `H_VIDEO`/`V_VIDEO`.
- One sub-module, `vga_box_mover`, holds the box position and direction registers and their per-LAP update. It is instantiated only under `VGA_RENDERER_BOUNCE_EN`.

## Test plan
- Reset asserted mid-line, mode=2 → RGB=0 and `frame_tick`=0 during reset; after deassertion the outputs stay black until the first LAP.
- mode=0, scan one full frame → every active pixel is RGB=F/F/F, 2 cycles after its coordinates. Blanking gives 0.
- mode=1 latched, line y=10 → x=79 is white; x=80 is yellow (F/F/0); x=559 is blue; x=560–639 is black.
- mode=2 → (31,0) is white?? no: (31,0) is black, (32,0) is white, (32,32) is black.
- mode=3, run 609 frames → box_x reaches 608 then 607 on the next frame with dir_x=0. box_y bounces at 448. `frame_tick` gives exactly 1 pulse per frame.
- Change `mode` mid-frame → old pattern holds until LAP; the new pattern starts on the first active pixel of the next frame.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern renderer: mode encoding,
// 3-bit bar colours, default raster size and the box-axis step function.
package vga_pkg;

  localparam int H_VIDEO_DEFAULT = 640;
  localparam int V_VIDEO_DEFAULT = 480;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_BOX     = 2'd3
  } mode_e;

  // One bit per channel, {r, g, b}; a set bit means full scale.
  typedef logic [2:0] rgb3_t;

  localparam rgb3_t RGB_WHITE   = 3'b111;
  localparam rgb3_t RGB_YELLOW  = 3'b110;
  localparam rgb3_t RGB_CYAN    = 3'b011;
  localparam rgb3_t RGB_GREEN   = 3'b010;
  localparam rgb3_t RGB_MAGENTA = 3'b101;
  localparam rgb3_t RGB_RED     = 3'b100;
  localparam rgb3_t RGB_BLUE    = 3'b001;
  localparam rgb3_t RGB_BLACK   = 3'b000;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;   // 1 = increasing
  } axis_t;

  function automatic rgb3_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

  // One bounce step along an axis whose legal range is [0, max_pos].
  function automatic axis_t axis_step(input axis_t cur, input logic [9:0] max_pos);
    axis_t nxt;
    nxt = cur;
    if (max_pos == '0) begin
      nxt = cur;                       // box spans the whole axis: nowhere to go
    end else if (cur.dir && cur.pos >= max_pos) begin
      nxt.dir = 1'b0;
      nxt.pos = cur.pos - 10'd1;
    end else if (!cur.dir && cur.pos == '0) begin
      nxt.dir = 1'b1;
      nxt.pos = 10'd1;
    end else begin
      nxt.pos = cur.dir ? cur.pos + 10'd1 : cur.pos - 10'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Position and direction registers of the bouncing box; advances one pixel
// per axis on each step pulse and reflects at the edges of the raster.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int H_VIDEO  = H_VIDEO_DEFAULT,
  parameter int V_VIDEO  = V_VIDEO_DEFAULT,
  parameter int BOX_SIZE = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  output logic [9:0] box_x,
  output logic [9:0] box_y
);

  localparam logic [9:0] MAX_X = 10'(H_VIDEO - BOX_SIZE);
  localparam logic [9:0] MAX_Y = 10'(V_VIDEO - BOX_SIZE);

  axis_t x_q;
  axis_t y_q;

  // NOTE: state uses <= so every flop samples pre-edge values; blocking '=' is
  // kept to combinational code and function temporaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '{pos: 10'd0, dir: 1'b1};
      y_q <= '{pos: 10'd0, dir: 1'b1};
    end else if (step) begin
      x_q <= axis_step(x_q, MAX_X);
      y_q <= axis_step(y_q, MAX_Y);
    end
  end

  assign box_x = x_q.pos;
  assign box_y = y_q.pos;

endmodule

// File: rtl/vga_pattern_renderer.sv
// Test-pattern renderer with a 2-stage pipeline from pixel coordinates to RGB.
// Define VGA_RENDERER_BOUNCE_EN to build the animated bouncing-box pattern.
module vga_pattern_renderer
  import vga_pkg::*;
#(
  parameter int COLOR_W      = 4,
  parameter int H_VIDEO      = H_VIDEO_DEFAULT,
  parameter int V_VIDEO      = V_VIDEO_DEFAULT,
  parameter int BOX_SIZE     = 32,
  parameter int CHECKER_LOG2 = 5
) (
  input  logic               clk_0,
  input  logic               rst,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               video_on,
  input  logic [1:0]         mode,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               frame_tick
);

  localparam int BAR_W = H_VIDEO / 8;

  mode_e active_mode;
  logic  lap;
  logic  started;
  logic  hold_black;
  logic  blank_now;
  logic  [2:0] bar_idx;
  rgb3_t pattern;
  rgb3_t pattern_q;
  logic  video_q;

  assign lap = video_on && (pixel_x == 10'(H_VIDEO - 1)) && (pixel_y == 10'(V_VIDEO - 1));

  // After reset a non-solid request stays black until the first frame boundary;
  // the decision is taken from the mode seen on the first cycle out of reset.
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      active_mode <= MODE_SOLID;
      frame_tick  <= 1'b0;
      started     <= 1'b0;
      hold_black  <= 1'b1;
    end else begin
      frame_tick <= lap;
      if (lap) begin
        active_mode <= mode_e'(mode);
        hold_black  <= 1'b0;
        started     <= 1'b1;
      end else if (!started) begin
        hold_black <= (mode_e'(mode) != MODE_SOLID);
        started    <= 1'b1;
      end
    end
  end

  assign blank_now = started ? hold_black : (mode_e'(mode) != MODE_SOLID);

  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(pixel_x) >= k * BAR_W) bar_idx = bar_idx + 3'd1;
    end
  end

`ifdef VGA_RENDERER_BOUNCE_EN
  logic [9:0] box_x;
  logic [9:0] box_y;
  logic       in_box;

  // The box only moves while it is the pattern on screen.
  vga_box_mover #(
    .H_VIDEO (H_VIDEO),
    .V_VIDEO (V_VIDEO),
    .BOX_SIZE(BOX_SIZE)
  ) u_box_mover (
    .clk  (clk_0),
    .rst_n(rst),
    .step (lap && (active_mode == MODE_BOX)),
    .box_x(box_x),
    .box_y(box_y)
  );

  assign in_box = ({1'b0, pixel_x} >= {1'b0, box_x}) &&
                  ({1'b0, pixel_x} <  {1'b0, box_x} + 11'(BOX_SIZE)) &&
                  ({1'b0, pixel_y} >= {1'b0, box_y}) &&
                  ({1'b0, pixel_y} <  {1'b0, box_y} + 11'(BOX_SIZE));
`endif

  // NOTE: default assignment first so every path drives pattern; no latch.
  always_comb begin
    pattern = RGB_BLACK;
    case (active_mode)
      MODE_SOLID:   pattern = RGB_WHITE;
      MODE_BARS:    pattern = bar_colour(bar_idx);
      MODE_CHECKER: pattern = (pixel_x[CHECKER_LOG2] ^ pixel_y[CHECKER_LOG2]) ? RGB_WHITE : RGB_BLACK;
`ifdef VGA_RENDERER_BOUNCE_EN
      MODE_BOX:     pattern = in_box ? RGB_WHITE : RGB_BLUE;
`else
      MODE_BOX:     pattern = RGB_BLACK;
`endif
      default:      pattern = RGB_BLACK;
    endcase
    if (blank_now) pattern = RGB_BLACK;
  end

  // NOTE: every pipeline flop is reset, not only the video flag, so the DAC
  // pins go black the instant rst falls.
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      pattern_q <= RGB_BLACK;
      video_q   <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
    end else begin
      pattern_q <= pattern;
      video_q   <= video_on;
      red       <= {COLOR_W{pattern_q[2] & video_q}};
      green     <= {COLOR_W{pattern_q[1] & video_q}};
      blue      <= {COLOR_W{pattern_q[0] & video_q}};
    end
  end

endmodule

// File: tb/tb_vga_pattern_renderer.sv
// Directed scoreboard bench for vga_pattern_renderer; box checks are built
// only when VGA_RENDERER_BOUNCE_EN is defined.
module tb_vga_pattern_renderer;

  localparam int CW = 4;

  logic          clk_0 = 1'b0;
  logic          rst = 1'b0;
  logic [9:0]    pixel_x = '0;
  logic [9:0]    pixel_y = '0;
  logic          video_on = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [CW-1:0] red, green, blue;
  logic          frame_tick;

  always #20 clk_0 = ~clk_0;

  vga_pattern_renderer dut (
    .clk_0     (clk_0),
    .rst       (rst),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .video_on  (video_on),
    .mode      (mode),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .frame_tick(frame_tick)
  );

  typedef struct packed {
    logic       chk;
    logic [2:0] code;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

`ifdef VGA_RENDERER_BOUNCE_EN
  int model_mode = 0;
  int bx = 0, by = 0;
  bit dx = 1'b1, dy = 1'b1;

  function automatic logic [2:0] m3_code(input int x, input int y);
    return (x >= bx && x < bx + 32 && y >= by && y < by + 32) ? 3'b111 : 3'b001;
  endfunction

  task automatic model_lap();
    if (model_mode == 3) begin
      if (dx) begin if (bx == 608) begin dx = 1'b0; bx--; end else bx++; end
      else    begin if (bx == 0)   begin dx = 1'b1; bx++; end else bx--; end
      if (dy) begin if (by == 448) begin dy = 1'b0; by--; end else by++; end
      else    begin if (by == 0)   begin dy = 1'b1; by++; end else by--; end
    end
    model_mode = int'(mode);
  endtask
`else
  function automatic logic [2:0] m3_code(input int x, input int y);
    return (x < 0 || y < 0) ? 3'b111 : 3'b000;
  endfunction
`endif

  function automatic logic [3*CW-1:0] expand(input logic [2:0] c);
    return {{CW{c[2]}}, {CW{c[1]}}, {CW{c[0]}}};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one pixel, clock it in, and retire the scoreboard entry whose
  // output is now visible (two edges after it was driven).
  task automatic step(input string tag, input int x, input int y, input logic von,
                      input logic [2:0] code, input logic chk);
    logic  lap;
    exp_t  e;
    string t;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    lap = von && (x == 639) && (y == 479);
    @(posedge clk_0); #1;
    exp_q.push_back('{chk: chk, code: code});
    tag_q.push_back(tag);
    if (exp_q.size() > 1) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (e.chk) check(t, 32'({red, green, blue}), 32'(expand(e.code)));
    end
    check({tag, "_tick"}, 32'(frame_tick), 32'(lap));
`ifdef VGA_RENDERER_BOUNCE_EN
    if (lap) model_lap();
`endif
  endtask

  task automatic enter_reset();
    rst = 1'b0;
    #1;
    check("async_rst_rgb", 32'({red, green, blue}), 32'd0);
    check("async_rst_tick", 32'(frame_tick), 32'd0);
    exp_q.delete();
    tag_q.delete();
`ifdef VGA_RENDERER_BOUNCE_EN
    model_mode = 0; bx = 0; by = 0; dx = 1'b1; dy = 1'b1;
`endif
  endtask

  int          bar_x[12]    = '{0, 79, 80, 159, 160, 240, 320, 400, 480, 559, 560, 639};
  logic [2:0]  bar_code[12] = '{3'b111, 3'b111, 3'b110, 3'b110, 3'b011, 3'b010,
                                3'b101, 3'b100, 3'b001, 3'b001, 3'b000, 3'b000};

  initial begin
    // Reset held mid-line with checkerboard requested.
    mode = 2'd2; pixel_x = 10'd100; pixel_y = 10'd50; video_on = 1'b1;
    repeat (3) @(posedge clk_0);
    #1;
    check("rst_rgb", 32'({red, green, blue}), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    @(negedge clk_0); rst = 1'b1;

    step("pre_lap_32_0", 32, 0, 1'b1, 3'b000, 1'b1);
    step("pre_lap_0_32", 0, 32, 1'b1, 3'b000, 1'b1);
    step("pre_lap_100_50", 100, 50, 1'b1, 3'b000, 1'b1);
    step("lap1", 639, 479, 1'b1, 3'b000, 1'b1);

    step("chk_31_0", 31, 0, 1'b1, 3'b000, 1'b1);
    step("chk_32_0", 32, 0, 1'b1, 3'b111, 1'b1);
    step("chk_32_32", 32, 32, 1'b1, 3'b000, 1'b1);
    step("chk_0_32", 0, 32, 1'b1, 3'b111, 1'b1);
    step("chk_blank", 32, 0, 1'b0, 3'b000, 1'b1);

    // Bars requested mid-frame: checkerboard holds through the LAP pixel.
    mode = 2'd1;
    step("chk_hold", 32, 0, 1'b1, 3'b111, 1'b1);
    step("lap2", 639, 479, 1'b1, 3'b111, 1'b1);
    for (int i = 0; i < 12; i++) step($sformatf("bar_x%0d", bar_x[i]), bar_x[i], 10, 1'b1, bar_code[i], 1'b1);
    step("bar_blank", 700, 10, 1'b0, 3'b000, 1'b1);

    // Solid white over full lines plus horizontal blanking.
    mode = 2'd0;
    step("lap3", 639, 479, 1'b1, 3'b000, 1'b1);
    for (int x = 0; x < 640; x++) step("solid_y0", x, 0, 1'b1, 3'b111, 1'b1);
    for (int x = 640; x < 800; x++) step("solid_hblank", x, 0, 1'b0, 3'b000, 1'b1);
    for (int x = 0; x < 639; x++) step("solid_y479", x, 479, 1'b1, 3'b111, 1'b1);

    mode = 2'd3;
    step("lap4", 639, 479, 1'b1, 3'b111, 1'b1);
`ifdef VGA_RENDERER_BOUNCE_EN
    step("box_0_0", 0, 0, 1'b1, 3'b111, 1'b1);
    step("box_31_31", 31, 31, 1'b1, 3'b111, 1'b1);
    step("box_32_0", 32, 0, 1'b1, 3'b001, 1'b1);
    step("box_0_32", 0, 32, 1'b1, 3'b001, 1'b1);
    for (int f = 0; f < 609; f++) begin
      step("box_lap", 639, 479, 1'b1, m3_code(639, 479), 1'b1);
      step("box_corner", bx, by, 1'b1, 3'b111, 1'b1);
      step("box_far", bx + 31, by + 31, 1'b1, 3'b111, 1'b1);
      if (f == 607) begin
        step("box_608_288", 608, 288, 1'b1, 3'b111, 1'b1);
        step("box_607_288", 607, 288, 1'b1, 3'b001, 1'b1);
        step("box_639_319", 639, 319, 1'b1, 3'b111, 1'b1);
        step("box_639_320", 639, 320, 1'b1, 3'b001, 1'b1);
      end
    end
    step("box_607_287", 607, 287, 1'b1, 3'b111, 1'b1);
    step("box_639_287", 639, 287, 1'b1, 3'b001, 1'b1);
    step("box_607_286", 607, 286, 1'b1, 3'b001, 1'b1);
    step("box_638_318", 638, 318, 1'b1, 3'b111, 1'b1);
`else
    step("m3_black_0_0", 0, 0, 1'b1, 3'b000, 1'b1);
    step("m3_black_320_240", 320, 240, 1'b1, 3'b000, 1'b1);
`endif

    // Mode change away from LAP is ignored until the boundary.
    mode = 2'd2;
    step("m3_hold", 32, 0, 1'b1, m3_code(32, 0), 1'b1);
    step("lap5", 639, 479, 1'b1, m3_code(639, 479), 1'b1);
    step("new_first", 32, 0, 1'b1, 3'b111, 1'b1);

    // Mid-frame reset with solid requested: resumes immediately.
    mode = 2'd0;
    step("lap6", 639, 479, 1'b1, 3'b111, 1'b1);
    step("solid_a", 5, 5, 1'b1, 3'b111, 1'b1);
    step("solid_b", 6, 5, 1'b1, 3'b111, 1'b1);
    step("solid_c", 7, 5, 1'b1, 3'b111, 1'b1);
    #3;
    enter_reset();
    @(negedge clk_0); rst = 1'b1;
    step("resume0_a", 5, 5, 1'b1, 3'b111, 1'b1);
    step("resume0_b", 6, 5, 1'b1, 3'b111, 1'b1);
    step("resume0_blank", 6, 5, 1'b0, 3'b000, 1'b1);

    // Mid-frame reset with bars requested: black until the first LAP.
    step("pre_rst2", 9, 9, 1'b1, 3'b111, 1'b1);
    enter_reset();
    mode = 2'd1;
    @(negedge clk_0); rst = 1'b1;
    step("hold_black_0", 0, 0, 1'b1, 3'b000, 1'b1);
    step("hold_black_80", 80, 0, 1'b1, 3'b000, 1'b1);
    step("lap7", 639, 479, 1'b1, 3'b000, 1'b1);
    step("bars_80", 80, 0, 1'b1, 3'b110, 1'b1);
    step("bars_560", 560, 0, 1'b1, 3'b000, 1'b1);
    step("flush_a", 0, 0, 1'b0, 3'b000, 1'b1);
    step("flush_b", 0, 0, 1'b0, 3'b000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
